// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types and constants for the FP normalize/round stage
package fp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fp_state_t;

  localparam int EXP_MAX = 255;
  localparam int BIAS    = 127;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] fraction;
  } fp32_t;

  localparam fp32_t POS_INF = '{sign: 1'b0, exponent: 8'hFF, fraction: 23'h0};
  localparam fp32_t ZERO    = '{sign: 1'b0, exponent: 8'h00, fraction: 23'h0};

endpackage

// File: rtl/fp_normalize_round_if.sv
// rtl/fp_normalize_round_if.sv - input beat / result handshake bundle for fp_normalize_round
interface fp_normalize_round_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exponent;
  logic [24:0] in_mantissa;
  logic        in_guard;
  logic        in_round;
  logic        in_sticky;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_overflow;
  logic        out_underflow;
  logic        out_inexact;

  modport master (
    output in_valid, in_sign, in_exponent, in_mantissa, in_guard, in_round, in_sticky, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exponent, in_mantissa, in_guard, in_round, in_sticky, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/round_nearest_even.sv
// rtl/round_nearest_even.sv - combinational round-to-nearest-even increment on a 25-bit mantissa
module round_nearest_even (
  input  logic [24:0] mant_i,
  input  logic        guard_i,
  input  logic        round_i,
  input  logic        sticky_i,
  output logic [24:0] mant_o,
  output logic        inexact_o
);
  logic inc;

  // A pure tie (guard only) rounds up only when that makes the lsb even
  assign inc       = guard_i & (round_i | sticky_i | mant_i[0]);
  assign mant_o    = mant_i + {24'b0, inc};
  assign inexact_o = guard_i | round_i | sticky_i;
endmodule

// File: rtl/fp_normalize_round.sv
// rtl/fp_normalize_round.sv - iterative normalize, RNE round and binary32 pack (FP_NORM_SUBNORMAL_EN enables gradual underflow)
module fp_normalize_round
  import fp_pkg::*;
#(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  fp_normalize_round_if.slave  bus
);
  localparam int SW = MANT_W + 2;
  localparam int XW = EXP_W + 1;

  fp_state_t       state_q, state_d;
  logic            sign_q, sign_d;
  logic [XW-1:0]   exp_q, exp_d, e_post;
  logic [SW-1:0]   mant_q, mant_d, rnd_mant;
  logic [SW-2:0]   m_post;
  logic            g_q, g_d, r_q, r_d, s_q, s_d;
  fp32_t           result_q, result_d;
  logic            ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
  logic            rnd_inx, norm_zero;

  round_nearest_even u_rne (
    .mant_i    (mant_q),
    .guard_i   (g_q),
    .round_i   (r_q),
    .sticky_i  (s_q),
    .mant_o    (rnd_mant),
    .inexact_o (rnd_inx)
  );

  assign norm_zero = (mant_q == '0) && !g_q && !r_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (bus.in_valid) state_d = ST_NORM;
      ST_NORM: begin
        if (mant_q[SW-1] || mant_q[SW-2]) state_d = ST_ROUND;
        else if (norm_zero)               state_d = ST_DONE;
        else if (exp_q == XW'(1))         state_d = ST_ROUND;
      end
      ST_ROUND: state_d = ST_DONE;
      ST_DONE:  if (bus.out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready      = (state_q == ST_IDLE);
    bus.out_valid     = (state_q == ST_DONE);
    bus.out_result    = result_q;
    bus.out_overflow  = ovf_q;
    bus.out_underflow = unf_q;
    bus.out_inexact   = inx_q;
  end

  always_comb begin
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    g_d      = g_q;
    r_d      = r_q;
    s_d      = s_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    m_post   = rnd_mant[SW-1] ? rnd_mant[SW-1:1] : rnd_mant[SW-2:0];
    e_post   = exp_q + XW'(rnd_mant[SW-1]);
    case (state_q)
      ST_IDLE: if (bus.in_valid) begin
        sign_d = bus.in_sign;
        // Exponent 0 and 1 share the same scale; holding 1 lets the subnormal stop fire
        exp_d  = (bus.in_exponent == '0) ? XW'(1) : XW'(bus.in_exponent);
        mant_d = SW'(bus.in_mantissa);
        g_d    = bus.in_guard;
        r_d    = bus.in_round;
        s_d    = bus.in_sticky;
      end
      ST_NORM: begin
        if (mant_q[SW-1]) begin
          mant_d = mant_q >> 1;
          exp_d  = exp_q + XW'(1);
          s_d    = s_q | r_q;
          r_d    = g_q;
          g_d    = mant_q[0];
        end else if (!mant_q[SW-2] && norm_zero) begin
          result_d      = ZERO;
          result_d.sign = sign_q;
          ovf_d         = 1'b0;
          unf_d         = 1'b0;
          inx_d         = s_q;
        end else if (!mant_q[SW-2] && exp_q != XW'(1)) begin
          {mant_d, g_d, r_d} = {mant_q[SW-2:0], g_q, r_q, 1'b0};
          exp_d              = exp_q - XW'(1);
        end
      end
      ST_ROUND: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = rnd_inx;
        if (e_post >= XW'(EXP_MAX)) begin
          result_d      = POS_INF;
          result_d.sign = sign_q;
          ovf_d         = 1'b1;
          inx_d         = 1'b1;
        end else if (!m_post[MANT_W]) begin
`ifdef FP_NORM_SUBNORMAL_EN
          result_d.sign     = sign_q;
          result_d.exponent = '0;
          result_d.fraction = m_post[MANT_W-1:0];
          unf_d             = rnd_inx;
`else
          result_d      = ZERO;
          result_d.sign = sign_q;
          unf_d         = 1'b1;
          inx_d         = 1'b1;
`endif
        end else begin
          result_d.sign     = sign_q;
          result_d.exponent = e_post[EXP_W-1:0];
          result_d.fraction = m_post[MANT_W-1:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_q   <= '0;
      g_q      <= 1'b0;
      r_q      <= 1'b0;
      s_q      <= 1'b0;
      result_q <= ZERO;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      g_q      <= g_d;
      r_q      <= r_d;
      s_q      <= s_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end
endmodule
